bsg_word_packet_gearbox: RTL and testbench

Width converter between the 32-bit host FIFO pairs produced by the AXI-Lite FIFO adapter and a wide packet interface on the fabric side. The TX path gathers consecutive 32-bit words dequeued from a host TX FIFO into one `packet_width_p`-bit packet. The RX path splits each wide response packet into 32-bit words for enqueue into the host RX FIFO. One instance serves one FIFO pair; the two paths are independent.

---
 rtl/bsg_word_packet_gearbox.sv | 143 ++++++++++++++
 tb/tb_bsg_word_packet_gearbox.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_word_packet_gearbox.sv
// Width converter between 32-bit host FIFO words and packet_width_p-bit fabric packets.
// TX gathers words into a packet (word 0 in the LSBs); RX splits a packet back into words.
module bsg_word_packet_gearbox #(
  parameter int unsigned packet_width_p = 128,
  localparam int unsigned words_lp = packet_width_p / 32,
  localparam int unsigned cnt_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic                      tx_v_i,
  input  logic [31:0]               tx_data_i,
  output logic                      tx_ready_o,

  output logic                      pkt_v_o,
  output logic [packet_width_p-1:0] pkt_data_o,
  input  logic                      pkt_ready_i,

  input  logic                      pkt_v_i,
  input  logic [packet_width_p-1:0] pkt_data_i,
  output logic                      pkt_ready_o,

  output logic                      rx_v_o,
  output logic [31:0]               rx_data_o,
  input  logic                      rx_ready_i,

  output logic [cnt_width_lp-1:0]   tx_cnt_o
);

  localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(words_lp - 1);
  localparam logic [cnt_width_lp-1:0] one_lp      = cnt_width_lp'(1);

  typedef enum logic {StTxFill, StTxSend} tx_state_e;
  typedef enum logic {StRxIdle, StRxSend} rx_state_e;

  // ---------------------------------------------------------------- TX assembler
  tx_state_e                 tx_state_q, tx_state_d;
  logic [cnt_width_lp-1:0]   tx_cnt_q, tx_cnt_d;
  logic [packet_width_p-1:0] buf_q;
  logic                      tx_accept;

  assign tx_accept = tx_v_i & (tx_state_q == StTxFill);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_state_q <= StTxFill;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Packet buffer is deliberately not reset; only counters and states are.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && tx_accept) begin
      buf_q[32*tx_cnt_q +: 32] <= tx_data_i;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    unique case (tx_state_q)
      StTxFill: begin
        if (tx_v_i) begin
          if (tx_cnt_q == last_idx_lp) begin
            tx_cnt_d   = '0;
            tx_state_d = StTxSend;
          end else begin
            tx_cnt_d = tx_cnt_q + one_lp;
          end
        end
      end
      StTxSend: begin
        if (pkt_ready_i) begin
          tx_state_d = StTxFill;
        end
      end
    endcase
  end

  always_comb begin
    tx_ready_o = reset_n_i & (tx_state_q == StTxFill);
    pkt_v_o    = (tx_state_q == StTxSend);
    pkt_data_o = buf_q;
    tx_cnt_o   = tx_cnt_q;
  end

  // ---------------------------------------------------------------- RX splitter
  rx_state_e                 rx_state_q, rx_state_d;
  logic [cnt_width_lp-1:0]   rx_idx_q, rx_idx_d;
  logic [packet_width_p-1:0] rbuf_q;
  logic                      rx_accept;

  assign rx_accept = pkt_v_i & (rx_state_q == StRxIdle);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_state_q <= StRxIdle;
      rx_idx_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && rx_accept) begin
      rbuf_q <= pkt_data_i;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    unique case (rx_state_q)
      StRxIdle: begin
        if (pkt_v_i) begin
          rx_idx_d   = '0;
          rx_state_d = StRxSend;
        end
      end
      StRxSend: begin
        if (rx_ready_i) begin
          if (rx_idx_q == last_idx_lp) begin
            rx_idx_d   = '0;
            rx_state_d = StRxIdle;
          end else begin
            rx_idx_d = rx_idx_q + one_lp;
          end
        end
      end
    endcase
  end

  always_comb begin
    pkt_ready_o = reset_n_i & (rx_state_q == StRxIdle);
    rx_v_o      = (rx_state_q == StRxSend);
    rx_data_o   = rbuf_q[32*rx_idx_q +: 32];
  end

endmodule

// File: tb/tb_bsg_word_packet_gearbox.sv
// Self-checking bench for bsg_word_packet_gearbox: table-driven directed scenarios,
// a hand-written mid-operation reset sequence, and a random soak against a queue model.
module tb_bsg_word_packet_gearbox;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tx_v;
  logic [31:0]  tx_data;
  logic         tx_ready;
  logic         pkt_v_out;
  logic [127:0] pkt_data_out;
  logic         pkt_ready_in;
  logic         pkt_v_in;
  logic [127:0] pkt_data_in;
  logic         pkt_ready_out;
  logic         rx_v;
  logic [31:0]  rx_data;
  logic         rx_ready;
  logic [1:0]   tx_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bsg_word_packet_gearbox #(.packet_width_p(128)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .tx_v_i      (tx_v),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .pkt_v_o     (pkt_v_out),
    .pkt_data_o  (pkt_data_out),
    .pkt_ready_i (pkt_ready_in),
    .pkt_v_i     (pkt_v_in),
    .pkt_data_i  (pkt_data_in),
    .pkt_ready_o (pkt_ready_out),
    .rx_v_o      (rx_v),
    .rx_data_o   (rx_data),
    .rx_ready_i  (rx_ready),
    .tx_cnt_o    (tx_cnt)
  );

  typedef struct {
    string        tag;
    logic         rst_n;
    logic         tx_v;
    logic [31:0]  tx_d;
    logic         pkt_rdy;
    logic         e_tx_rdy;
    logic         e_pkt_v;
    logic [1:0]   e_cnt;
    logic [127:0] e_pkt_d;
    logic         pkt_v;
    logic [127:0] pkt_d;
    logic         rx_rdy;
    logic         e_pkt_rdy;
    logic         e_rx_v;
    logic [31:0]  e_rx_d;
  } vec_t;

  // TX-only row; RX side idle and expected idle
  function automatic vec_t txr(string tag, logic v, logic [31:0] d, logic prdy, logic etr,
                               logic epv, logic [1:0] ec, logic [127:0] epd);
    vec_t r;
    r.tag = tag; r.rst_n = 1'b1;
    r.tx_v = v; r.tx_d = d; r.pkt_rdy = prdy;
    r.e_tx_rdy = etr; r.e_pkt_v = epv; r.e_cnt = ec; r.e_pkt_d = epd;
    r.pkt_v = 1'b0; r.pkt_d = 128'd0; r.rx_rdy = 1'b0;
    r.e_pkt_rdy = 1'b1; r.e_rx_v = 1'b0; r.e_rx_d = 32'd0;
    return r;
  endfunction

  // RX-only row; TX side idle and expected empty
  function automatic vec_t rxr(string tag, logic pv, logic [127:0] pd, logic rrdy,
                               logic eprdy, logic erxv, logic [31:0] erxd);
    vec_t r;
    r = txr(tag, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0);
    r.pkt_v = pv; r.pkt_d = pd; r.rx_rdy = rrdy;
    r.e_pkt_rdy = eprdy; r.e_rx_v = erxv; r.e_rx_d = erxd;
    return r;
  endfunction

  function automatic vec_t merge(vec_t a, vec_t b);
    vec_t r;
    r = a;
    r.tag = {a.tag, "+", b.tag};
    r.pkt_v = b.pkt_v; r.pkt_d = b.pkt_d; r.rx_rdy = b.rx_rdy;
    r.e_pkt_rdy = b.e_pkt_rdy; r.e_rx_v = b.e_rx_v; r.e_rx_d = b.e_rx_d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit do_chk);
    reset_n      = v.rst_n;
    tx_v         = v.tx_v;
    tx_data      = v.tx_d;
    pkt_ready_in = v.pkt_rdy;
    pkt_v_in     = v.pkt_v;
    pkt_data_in  = v.pkt_d;
    rx_ready     = v.rx_rdy;
    #1;
    if (do_chk) begin
      chk({v.tag, ".tx_ready"},  128'(tx_ready),      128'(v.e_tx_rdy));
      chk({v.tag, ".pkt_v"},     128'(pkt_v_out),     128'(v.e_pkt_v));
      chk({v.tag, ".tx_cnt"},    128'(tx_cnt),        128'(v.e_cnt));
      chk({v.tag, ".pkt_ready"}, 128'(pkt_ready_out), 128'(v.e_pkt_rdy));
      chk({v.tag, ".rx_v"},      128'(rx_v),          128'(v.e_rx_v));
      if (v.e_pkt_v) chk({v.tag, ".pkt_data"}, pkt_data_out, v.e_pkt_d);
      if (v.e_rx_v)  chk({v.tag, ".rx_data"}, 128'(rx_data), 128'(v.e_rx_d));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t s1[$];
  vec_t s3[$];
  vec_t rst_row;
  vec_t idle_tx;

  logic [127:0] pkt_abcd;
  logic [127:0] pkt_junk;

  // Soak model state
  logic [31:0]  m_txw[$];
  bit           m_tx_pend;
  logic [127:0] m_tx_pkt;
  logic [31:0]  m_rxw[$];
  int           n_tx_pkts;
  int           n_rx_words;

  initial begin
    pkt_abcd = {32'hD, 32'hC, 32'hB, 32'hA};
    pkt_junk = {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
    idle_tx  = txr("txidle", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0);

    // Reset state: ready outputs forced low while reset is held, then the release cycle
    rst_row = idle_tx;
    rst_row.tag = "rst"; rst_row.rst_n = 1'b0; rst_row.e_tx_rdy = 1'b0; rst_row.e_pkt_rdy = 1'b0;
    tbl.push_back(rst_row);
    tbl.push_back(txr("rel", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0));

    // Scenario 1: back-to-back TX assembly, tx_v held high through the send cycle
    s1.push_back(txr("s1w0", 1'b1, 32'd11, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0));
    s1.push_back(txr("s1w1", 1'b1, 32'd22, 1'b1, 1'b1, 1'b0, 2'd1, 128'd0));
    s1.push_back(txr("s1w2", 1'b1, 32'd33, 1'b1, 1'b1, 1'b0, 2'd2, 128'd0));
    s1.push_back(txr("s1w3", 1'b1, 32'd44, 1'b1, 1'b1, 1'b0, 2'd3, 128'd0));
    s1.push_back(txr("s1pkt", 1'b1, 32'd55, 1'b1, 1'b0, 1'b1, 2'd0,
                     {32'd44, 32'd33, 32'd22, 32'd11}));
    s1.push_back(txr("s1done", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0));

    // Scenario 3: RX split with alternating rx_ready; a junk packet is offered meanwhile
    s3.push_back(rxr("s3pkt", 1'b1, pkt_abcd, 1'b1, 1'b1, 1'b0, 32'd0));
    s3.push_back(rxr("s3a",   1'b1, pkt_junk, 1'b1, 1'b0, 1'b1, 32'hA));
    s3.push_back(rxr("s3b0",  1'b1, pkt_junk, 1'b0, 1'b0, 1'b1, 32'hB));
    s3.push_back(rxr("s3b1",  1'b1, pkt_junk, 1'b1, 1'b0, 1'b1, 32'hB));
    s3.push_back(rxr("s3c0",  1'b1, pkt_junk, 1'b0, 1'b0, 1'b1, 32'hC));
    s3.push_back(rxr("s3c1",  1'b1, pkt_junk, 1'b1, 1'b0, 1'b1, 32'hC));
    s3.push_back(rxr("s3d0",  1'b1, pkt_junk, 1'b0, 1'b0, 1'b1, 32'hD));
    s3.push_back(rxr("s3d1",  1'b1, pkt_junk, 1'b1, 1'b0, 1'b1, 32'hD));
    s3.push_back(rxr("s3end", 1'b0, 128'd0,   1'b0, 1'b1, 1'b0, 32'd0));
    s3.push_back(rxr("s3idle", 1'b0, 128'd0,  1'b1, 1'b1, 1'b0, 32'd0));

    foreach (s1[i]) tbl.push_back(s1[i]);

    // Scenario 2: packet held under backpressure, extra words refused, then AA lands in slot 0
    for (int i = 0; i < W; i++)
      tbl.push_back(txr("s2w", 1'b1, 32'(i + 1), 1'b0, 1'b1, 1'b0, 2'(i), 128'd0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(txr("s2hold", 1'b1, 32'hBAD, 1'b0, 1'b0, 1'b1, 2'd0,
                        {32'd4, 32'd3, 32'd2, 32'd1}));
    tbl.push_back(txr("s2rel", 1'b1, 32'hBAD, 1'b1, 1'b0, 1'b1, 2'd0,
                      {32'd4, 32'd3, 32'd2, 32'd1}));
    tbl.push_back(txr("s2aa", 1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0));
    tbl.push_back(txr("s2bb", 1'b1, 32'hBB, 1'b1, 1'b1, 1'b0, 2'd1, 128'd0));
    tbl.push_back(txr("s2cc", 1'b1, 32'hCC, 1'b1, 1'b1, 1'b0, 2'd2, 128'd0));
    tbl.push_back(txr("s2dd", 1'b1, 32'hDD, 1'b1, 1'b1, 1'b0, 2'd3, 128'd0));
    tbl.push_back(txr("s2pkt", 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 2'd0,
                      {32'hDD, 32'hCC, 32'hBB, 32'hAA}));
    tbl.push_back(idle_tx);

    foreach (s3[i]) tbl.push_back(s3[i]);

    // Scenario 4: scenarios 1 and 3 in the same cycles
    foreach (s3[i]) tbl.push_back(merge((i < s1.size()) ? s1[i] : idle_tx, s3[i]));

    // Bring the DUT out of its power-up state before the table
    apply(rst_row, 1'b0);
    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Scenario 5: reset after 2 TX words and 1 RX word
    apply(merge(txr("r5w0", 1'b1, 32'h111, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0),
                rxr("r5pkt", 1'b1, pkt_abcd, 1'b1, 1'b1, 1'b0, 32'd0)), 1'b1);
    apply(merge(txr("r5w1", 1'b1, 32'h222, 1'b1, 1'b1, 1'b0, 2'd1, 128'd0),
                rxr("r5a", 1'b0, 128'd0, 1'b1, 1'b0, 1'b1, 32'hA)), 1'b1);
    rst_row.tx_v = 1'b1; rst_row.tx_d = 32'h333;
    apply(rst_row, 1'b0);
    rst_row.tag = "r5rst";
    apply(rst_row, 1'b1);
    apply(txr("r5rel", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0), 1'b1);
    for (int i = 0; i < W; i++)
      apply(txr("r5w", 1'b1, 32'(i + 5), 1'b1, 1'b1, 1'b0, 2'(i), 128'd0), 1'b1);
    apply(txr("r5pkt", 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 2'd0, {32'd8, 32'd7, 32'd6, 32'd5}), 1'b1);
    apply(txr("r5idle", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 128'd0), 1'b1);

    // Scenario 6: random soak against a queue-level model
    m_tx_pend = 1'b0;
    n_tx_pkts = 0;
    n_rx_words = 0;
    reset_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      tx_v         = ($urandom_range(0, 3) != 0);
      tx_data      = $urandom;
      pkt_ready_in = ($urandom_range(0, 2) != 0);
      pkt_v_in     = ($urandom_range(0, 1) != 0);
      pkt_data_in  = {$urandom, $urandom, $urandom, $urandom};
      rx_ready     = ($urandom_range(0, 3) != 0);
      #1;
      chk("soak.tx_ready", 128'(tx_ready), 128'(!m_tx_pend));
      chk("soak.pkt_v", 128'(pkt_v_out), 128'(m_tx_pend));
      if (m_tx_pend) chk("soak.pkt_data", pkt_data_out, m_tx_pkt);
      chk("soak.tx_cnt", 128'(tx_cnt), 128'(m_txw.size()));
      chk("soak.pkt_ready", 128'(pkt_ready_out), 128'(m_rxw.size() == 0));
      chk("soak.rx_v", 128'(rx_v), 128'(m_rxw.size() != 0));
      if (m_rxw.size() != 0) chk("soak.rx_data", 128'(rx_data), 128'(m_rxw[0]));
      @(posedge clk);
      if (m_tx_pend) begin
        if (pkt_ready_in) begin
          m_tx_pend = 1'b0;
          n_tx_pkts++;
        end
      end else if (tx_v) begin
        m_txw.push_back(tx_data);
        if (m_txw.size() == W) begin
          m_tx_pkt = {m_txw[3], m_txw[2], m_txw[1], m_txw[0]};
          m_txw.delete();
          m_tx_pend = 1'b1;
        end
      end
      if (m_rxw.size() == 0) begin
        if (pkt_v_in) for (int k = 0; k < W; k++) m_rxw.push_back(pkt_data_in[32*k +: 32]);
      end else if (rx_ready) begin
        void'(m_rxw.pop_front());
        n_rx_words++;
      end
      #1;
    end
    n_cmp++;
    if (n_tx_pkts == 0 || n_rx_words == 0) begin
      n_fail++;
      $display("FAIL soak.traffic: got %0d tx packets / %0d rx words, want both nonzero",
               n_tx_pkts, n_rx_words);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
